// File: rtl/j_mac_accum.sv
// 40-bit signed multiply-accumulate for the Jerry DSP datapath: three-stage pipeline
// (operand capture, product/load formation, accumulate) with a sticky signed-overflow flag.
module j_mac_accum #(
    parameter int ACC_W = 40,
    parameter int OP_W  = 16
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [31:0]     acc_lo,
    output logic [7:0]      acc_hi,
    output logic            ovf
);

    localparam int STAGES = 3;
    localparam int PROD_W = 2 * OP_W;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_MAC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef struct packed {
        op_e             op;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    s1_t             s1_q;
    op_e             op2_q;
    logic [ACC_W-1:0] addend_q;
    logic [ACC_W-1:0] acc_q;
    logic            ovf_q;

    // S2 operand: the signed product, or the raw {a, b} word for LOAD.
    logic signed [PROD_W-1:0] mult_c;
    logic [PROD_W-1:0]        s2_word_c;
    logic [ACC_W-1:0]         s2_ext_c;

    assign mult_c    = $signed(s1_q.a) * $signed(s1_q.b);
    assign s2_word_c = (s1_q.op == OP_LOAD) ? {s1_q.a, s1_q.b} : mult_c;
    assign s2_ext_c  = {{(ACC_W-PROD_W){s2_word_c[PROD_W-1]}}, s2_word_c};

    // S3 accumulate; overflow when like-signed addends give a result of the other sign.
    logic [ACC_W-1:0] sum_c;
    logic             mac_ovf_c;

    assign sum_c     = acc_q + addend_q;
    assign mac_ovf_c = (acc_q[ACC_W-1] == addend_q[ACC_W-1]) &&
                       (sum_c[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            op2_q    <= OP_MULT;
            addend_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], start};
            if (start) begin
                s1_q <= '{op: op_e'(op), a: a, b: b};
            end
            if (vld_pipe[1]) begin
                op2_q    <= s1_q.op;
                addend_q <= s2_ext_c;
            end
            if (vld_pipe[2]) begin
                case (op2_q)
                    OP_MULT: begin
                        acc_q <= addend_q;
                        ovf_q <= 1'b0;
                    end
                    OP_MAC: begin
                        acc_q <= sum_c;
                        ovf_q <= ovf_q | mac_ovf_c;
                    end
                    OP_CLR: begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    OP_LOAD: begin
                        acc_q <= addend_q;
                        ovf_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The retire-stage valid bit doubles as the done pulse.
    assign done   = vld_pipe[STAGES];
    assign busy   = |vld_pipe;
    assign acc_lo = acc_q[31:0];
    assign acc_hi = acc_q[ACC_W-1:32];
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_j_mac_accum.sv
// Self-checking bench for j_mac_accum: directed corner cases plus a randomized
// op stream checked against an integer-arithmetic accumulator model.
module tb_j_mac_accum;

    localparam logic [1:0] MULT = 2'b00, MAC = 2'b01, CLR = 2'b10, LOAD = 2'b11;
    localparam longint TWO39 = 64'sd549755813888;
    localparam longint TWO40 = 64'sd1099511627776;
    localparam int N_RAND = 400;

    logic        sys_clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, ovf;
    logic [31:0] acc_lo;
    logic [7:0]  acc_hi;

    int vectors = 0;
    int miscompares = 0;

    longint m_acc;
    bit     m_ovf;

    j_mac_accum dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .acc_lo(acc_lo), .acc_hi(acc_hi), .ovf(ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        start = s; op = o; a = x; b = y;
    endtask

    // Issue one op and advance to the cycle where it should be retiring.
    task automatic issue_wait(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        drive(1'b1, o, x, y);
        step();
        drive(1'b0, MULT, 16'h0, 16'h0);
        step();
        step();
    endtask

    function automatic longint wrap40(input longint x);
        longint r;
        r = x % TWO40;
        if (r < 0) r += TWO40;
        if (r >= TWO39) r -= TWO40;
        return r;
    endfunction

    function automatic void model_apply(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        longint p, s;
        p = longint'($signed(x)) * longint'($signed(y));
        case (o)
            MULT: begin m_acc = p; m_ovf = 1'b0; end
            MAC: begin
                s = m_acc + p;
                if (s >= TWO39 || s < -TWO39) m_ovf = 1'b1;
                m_acc = wrap40(s);
            end
            CLR:  begin m_acc = 0; m_ovf = 1'b0; end
            default: begin m_acc = longint'($signed({x, y})); m_ovf = 1'b0; end
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, MAC, 16'h7FFF, 16'h7FFF);
        step();
        step();
        vectors++;
        if ({busy, done, ovf, acc_hi, acc_lo} !== 43'h0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b ovf=%b acc=%h_%h want all zero", busy, done, ovf, acc_hi, acc_lo);
        end
        reset = 1'b0;
        drive(1'b0, MULT, 16'h0, 16'h0);
        step();
        step();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_dominates_start got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_mult();
        drive(1'b1, MULT, 16'h7FFF, 16'h7FFF);
        step();
        drive(1'b0, MULT, 16'h0, 16'h0);
        step();
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL mult_latency_n1 got busy=%b done=%b want 1 0", busy, done);
        end
        step();
        vectors++;
        if ({done, ovf, acc_hi, acc_lo} !== {1'b1, 1'b0, 8'h00, 32'h3FFF0001}) begin
            miscompares++;
            $display("FAIL mult_max got done=%b ovf=%b acc=%h_%h want 1 0 00_3fff0001", done, ovf, acc_hi, acc_lo);
        end
        step();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL mult_idle got busy=%b done=%b want 0 0", busy, done);
        end
        issue_wait(MULT, 16'h8000, 16'h7FFF);
        vectors++;
        if ({done, acc_hi, acc_lo} !== {1'b1, 8'hFF, 32'hC0008000}) begin
            miscompares++;
            $display("FAIL mult_neg got done=%b acc=%h_%h want 1 ff_c0008000", done, acc_hi, acc_lo);
        end
    endtask

    task automatic test_mac_chain();
        int cnt = 0;
        drive(1'b1, CLR, 16'h0, 16'h0);
        step();
        if (done === 1'b1) cnt++;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, MAC, 16'h7FFF, 16'h7FFF);
            step();
            if (done === 1'b1) cnt++;
        end
        drive(1'b0, MULT, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1) cnt++;
        end
        vectors++;
        if (cnt !== 257) begin
            miscompares++;
            $display("FAIL mac_chain_done_count got %0d want 257", cnt);
        end
        vectors++;
        if ({ovf, acc_hi, acc_lo} !== {1'b0, 8'h3F, 32'hFF000100}) begin
            miscompares++;
            $display("FAIL mac_chain_acc got ovf=%b acc=%h_%h want 0 3f_ff000100", ovf, acc_hi, acc_lo);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, CLR, 16'h0, 16'h0);
        step();
        for (int i = 0; i < 511; i++) begin
            drive(1'b1, MAC, 16'h8000, 16'h8000);
            step();
        end
        drive(1'b0, MULT, 16'h0, 16'h0);
        step(); step(); step();
        vectors++;
        if ({ovf, acc_hi, acc_lo} !== {1'b0, 8'h7F, 32'hC0000000}) begin
            miscompares++;
            $display("FAIL ovf_511 got ovf=%b acc=%h_%h want 0 7f_c0000000", ovf, acc_hi, acc_lo);
        end
        issue_wait(MAC, 16'h8000, 16'h8000);
        vectors++;
        if ({ovf, acc_hi, acc_lo} !== {1'b1, 8'h80, 32'h00000000}) begin
            miscompares++;
            $display("FAIL ovf_512 got ovf=%b acc=%h_%h want 1 80_00000000", ovf, acc_hi, acc_lo);
        end
        issue_wait(MAC, 16'h0001, 16'h0001);
        vectors++;
        if ({ovf, acc_hi, acc_lo} !== {1'b1, 8'h80, 32'h00000001}) begin
            miscompares++;
            $display("FAIL ovf_sticky got ovf=%b acc=%h_%h want 1 80_00000001", ovf, acc_hi, acc_lo);
        end
        issue_wait(MULT, 16'h0001, 16'h0001);
        vectors++;
        if ({ovf, acc_hi, acc_lo} !== {1'b0, 8'h00, 32'h00000001}) begin
            miscompares++;
            $display("FAIL ovf_mult_clears got ovf=%b acc=%h_%h want 0 00_00000001", ovf, acc_hi, acc_lo);
        end
    endtask

    task automatic test_load();
        issue_wait(LOAD, 16'h8001, 16'h0002);
        vectors++;
        if ({done, ovf, acc_hi, acc_lo} !== {1'b1, 1'b0, 8'hFF, 32'h80010002}) begin
            miscompares++;
            $display("FAIL load got done=%b ovf=%b acc=%h_%h want 1 0 ff_80010002", done, ovf, acc_hi, acc_lo);
        end
        issue_wait(MAC, 16'h0001, 16'h0001);
        vectors++;
        if ({acc_hi, acc_lo} !== {8'hFF, 32'h80010003}) begin
            miscompares++;
            $display("FAIL load_then_mac got acc=%h_%h want ff_80010003", acc_hi, acc_lo);
        end
    endtask

    task automatic test_back_to_back();
        issue_wait(MULT, 16'h1234, 16'h0010);
        drive(1'b1, CLR, 16'h0, 16'h0);
        step();
        drive(1'b1, MAC, 16'hFFFD, 16'h0007);
        step();
        drive(1'b0, MULT, 16'h0, 16'h0);
        step();
        vectors++;
        if ({done, acc_hi, acc_lo} !== {1'b1, 8'h00, 32'h00000000}) begin
            miscompares++;
            $display("FAIL b2b_clr got done=%b acc=%h_%h want 1 00_00000000", done, acc_hi, acc_lo);
        end
        step();
        vectors++;
        if ({done, acc_hi, acc_lo} !== {1'b1, 8'hFF, 32'hFFFFFFEB}) begin
            miscompares++;
            $display("FAIL b2b_mac got done=%b acc=%h_%h want 1 ff_ffffffeb", done, acc_hi, acc_lo);
        end
    endtask

    task automatic test_reset_mid();
        issue_wait(LOAD, 16'h0000, 16'h0005);
        vectors++;
        if ({acc_hi, acc_lo} !== {8'h00, 32'h00000005}) begin
            miscompares++;
            $display("FAIL rmid_load got acc=%h_%h want 00_00000005", acc_hi, acc_lo);
        end
        drive(1'b1, MAC, 16'h0003, 16'h0003);
        step();
        drive(1'b0, MULT, 16'h0, 16'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({busy, done, ovf, acc_hi, acc_lo} !== 43'h0) begin
            miscompares++;
            $display("FAIL rmid_after_reset got busy=%b done=%b acc=%h_%h want 0 0 00_00000000", busy, done, acc_hi, acc_lo);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({done, acc_hi, acc_lo} !== 41'h0) begin
                miscompares++;
                $display("FAIL rmid_no_retire got done=%b acc=%h_%h want 0 00_00000000", done, acc_hi, acc_lo);
            end
        end
        issue_wait(MAC, 16'h0100, 16'hFF00);
        vectors++;
        if ({done, acc_hi, acc_lo} !== {1'b1, 8'hFF, 32'hFFFF0000}) begin
            miscompares++;
            $display("FAIL rmid_mac_after got done=%b acc=%h_%h want 1 ff_ffff0000", done, acc_hi, acc_lo);
        end
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic test_random();
        bit          pv [0:N_RAND+1];
        logic [1:0]  po [0:N_RAND+1];
        logic [15:0] pa [0:N_RAND+1];
        logic [15:0] pb [0:N_RAND+1];
        logic [39:0] e;
        bit          e_done, e_busy;
        reset = 1'b1;
        drive(1'b0, MULT, 16'h0, 16'h0);
        step();
        reset = 1'b0;
        m_acc = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < N_RAND + 2; i++) begin
            pv[i] = 1'b0; po[i] = MULT; pa[i] = 16'h0; pb[i] = 16'h0;
        end
        for (int i = 0; i < N_RAND + 2; i++) begin
            if (i < N_RAND) begin
                pv[i] = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 9))
                    0, 1:    po[i] = MULT;
                    2:       po[i] = CLR;
                    3:       po[i] = LOAD;
                    default: po[i] = MAC;
                endcase
                pa[i] = rand_operand();
                pb[i] = rand_operand();
            end
            drive(pv[i], po[i], pa[i], pb[i]);
            step();
            e_done = (i >= 2) ? pv[i-2] : 1'b0;
            e_busy = pv[i] | ((i >= 1) ? pv[i-1] : 1'b0) | e_done;
            if (e_done) model_apply(po[i-2], pa[i-2], pb[i-2]);
            e = m_acc[39:0];
            vectors++;
            if ({done, busy, ovf, acc_hi, acc_lo} !== {e_done, e_busy, m_ovf, e}) begin
                miscompares++;
                $display("FAIL random[%0d] got done=%b busy=%b ovf=%b acc=%h_%h want %b %b %b %h", i, done, busy, ovf, acc_hi, acc_lo, e_done, e_busy, m_ovf, e);
            end
        end
        drive(1'b0, MULT, 16'h0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, MULT, 16'h0, 16'h0);
        test_reset();
        test_mult();
        test_mac_chain();
        test_overflow();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/j_mac_accum.md
Name: j_mac_accum

Overview:
- 40-bit signed multiply-accumulate unit for the Jerry DSP datapath.
- Produces the accumulator value consumed by the accumulator saturation stage: low 32 bits go to its data input, high 8 bits to its guard-bit inputs.
- Three-stage pipeline that accepts one operation per cycle.
- Accumulator wraps modulo 2^40. A sticky overflow flag records signed overflow.

Parameters:
- ACC_W, 40, accumulator width; fixed at 40 because the saturation stage consumes 32 + 8 bits.
- OP_W, 16, multiplier operand width; signed two's complement.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  accept one operation this cycle; no backpressure.
- op  in  2  operation: 00 MULT, 01 MAC, 10 CLR, 11 LOAD.
- a  in  16  signed operand A.
- b  in  16  signed operand B.
- busy  out  1  high while any pipeline stage holds a valid operation.
- done  out  1  one-cycle pulse when an operation retires into the accumulator.
- acc_lo  out  32  accumulator bits 31..0.
- acc_hi  out  8  accumulator bits 39..32 (guard bits).
- ovf  out  1  sticky signed-overflow flag.

Behaviour:
- Reset: all outputs are 0. That is acc = 0x0000000000, ovf = 0, done = 0, busy = 0, and all stage valid bits are cleared.
- Reset dominates start in the same cycle.
- Reset mid-operation: in-flight operations are discarded, with no done pulse and no accumulator update.
- Stage S1 (the start edge): registers op, a and b, and sets v1.
- Stage S2: computes the signed 16x16 product into a 32-bit product register.
  - Sign-extends product to 40 bits. Sets v2.
  - For LOAD, S2 instead forms {a, b} as 32 bits, sign-extended from a[15].
- Stage S3 updates the accumulator, pulses done, and drives busy low if nothing else is in flight:
  - MULT: acc = product, ovf = 0.
  - MAC: acc = acc + product, mod 2^40. Sets ovf when both addend signs are equal and the result sign differs; otherwise ovf holds.
  - CLR: acc = 0, ovf = 0.
  - LOAD: acc = the sign-extended {a, b}, ovf = 0.
- Latency: start at edge N gives the accumulator update and done at edge N+2.
  - acc_lo/acc_hi show the new value in the cycle following edge N+2, with done high in that same cycle.
- Back-to-back operations:
  - S3 always uses the current accumulator register, so consecutive MACs chain without stalls or bubbles.
  - CLR followed by MAC on the next cycle yields exactly that MAC's product.
- busy = v1 | v2 | v3.
- start is accepted every cycle regardless of busy.
- Product range:
  - 0x8000*0x8000 = +0x40000000, represented positive in 40 bits; no 32-bit product overflow.
  - 0x8000*0x7FFF = -0x3FFF8000.
- acc_lo and acc_hi are direct register outputs with no combinational path from the inputs.
- op value when start = 0 is ignored.

Test Plan:
- MULT a = 0x7FFF, b = 0x7FFF, start at edge 0 -> done at edge 2; acc_hi = 0x00, acc_lo = 0x3FFF0001, ovf = 0, busy low afterwards.
- MULT a = 0x8000, b = 0x7FFF -> acc_hi = 0xFF, acc_lo = 0xC0008000.
- CLR, then 256 consecutive MACs of 0x7FFF*0x7FFF with start held high -> 257 done pulses; final acc_hi = 0x3F, acc_lo = 0xFF000100, ovf = 0.
- CLR, then 512 MACs of 0x8000*0x8000:
  - After 511: acc_hi = 0x7F, acc_lo = 0xC0000000, ovf = 0.
  - After 512: acc_hi = 0x80, acc_lo = 0x00000000, ovf = 1.
  - A following MULT clears ovf.
- LOAD a = 0x8001, b = 0x0002 -> acc_hi = 0xFF, acc_lo = 0x80010002. Then MAC 0x0001*0x0001 -> acc_lo = 0x80010003.
- Load acc = 0x0000000005, issue MAC 3*3, assert reset one cycle later -> no done; acc = 0 and busy = 0 after the reset edge; a MAC issued right after reset yields exactly its product.
